// File: rtl/regfile_sb.sv
// Dual-write register file with combinational read ports, optional write-through bypass,
// optional hardwired-zero entry 0 and a per-entry busy scoreboard for RAW hazard detection.
module regfile_sb #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddrA,
    input  logic [ADDR_W-1:0] raddrB,
    output logic [DATA_W-1:0] rdataA,
    output logic [DATA_W-1:0] rdataB,
    output logic              rbusyA,
    output logic              rbusyB,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic [ADDR_W:0]   busy_cnt,
    output logic              err_waw
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [DEPTH-1:0]  clr;
    logic [DEPTH-1:0]  set;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              err_nxt;
    logic              we0_ok;
    logic              we1_ok;
    logic              issue_ok;

    // Entry 0 is invisible to writes and issues when hardwired to zero
    assign we0_ok   = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
    assign we1_ok   = we1 && !((ZERO_REG != 0) && (waddr1 == '0));
    assign issue_ok = issue_en && !((ZERO_REG != 0) && (issue_addr == '0));

    // Storage: port 1 is written last so it wins an address collision
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (we0_ok) begin
                mem[waddr0] <= wdata0;
            end
            if (we1_ok) begin
                mem[waddr1] <= wdata1;
            end
        end
    end

    // Scoreboard next state: writes clear, issue sets, set beats clear
    always_comb begin
        clr     = '0;
        set     = '0;
        cnt_nxt = '0;
        if (we0_ok) begin
            clr[waddr0] = 1'b1;
        end
        if (we1_ok) begin
            clr[waddr1] = 1'b1;
        end
        if (issue_ok) begin
            set[issue_addr] = 1'b1;
        end
        busy_nxt = (busy & ~clr) | set;
        for (int i = 0; i < int'(DEPTH); i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
        end
        err_nxt = err_waw | (issue_ok & busy[issue_addr] & ~clr[issue_addr]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
            err_waw  <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
            err_waw  <= err_nxt;
        end
    end

    // One read port: stored value, optionally overridden by same-cycle writes
    function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] ra);
        logic [DATA_W-1:0] d;
        logic              b;
        d = mem[ra];
        b = busy[ra];
        if (BYPASS != 0) begin
            if (we0_ok && (waddr0 == ra)) begin
                d = wdata0;
                b = 1'b0;
            end
            if (we1_ok && (waddr1 == ra)) begin
                d = wdata1;
                b = 1'b0;
            end
        end
        if ((ZERO_REG != 0) && (ra == '0)) begin
            d = '0;
            b = 1'b0;
        end
        return {b, d};
    endfunction

    always_comb begin
        {rbusyA, rdataA} = read_port(raddrA);
        {rbusyB, rdataB} = read_port(raddrB);
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: three instances (bypass, no bypass, zero register)
// share one stimulus stream; each check targets the instance whose behaviour it exercises.
module tb_regfile_sb;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          we0, we1, issue_en;
    logic [AW-1:0] waddr0, waddr1, raddrA, raddrB, issue_addr;
    logic [DW-1:0] wdata0, wdata1;

    logic [DW-1:0] b_rdA, b_rdB, n_rdA, n_rdB, z_rdA, z_rdB;
    logic          b_rbA, b_rbB, n_rbA, n_rbB, z_rbA, z_rbB;
    logic [AW:0]   b_cnt, n_cnt, z_cnt;
    logic          b_err, n_err, z_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1), .ZERO_REG(0)) u_byp (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddrA(raddrA), .raddrB(raddrB),
        .rdataA(b_rdA), .rdataB(b_rdB), .rbusyA(b_rbA), .rbusyB(b_rbB),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .busy_cnt(b_cnt), .err_waw(b_err)
    );

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0), .ZERO_REG(0)) u_nobyp (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddrA(raddrA), .raddrB(raddrB),
        .rdataA(n_rdA), .rdataB(n_rdB), .rbusyA(n_rbA), .rbusyB(n_rbB),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .busy_cnt(n_cnt), .err_waw(n_err)
    );

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1), .ZERO_REG(1)) u_zero (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddrA(raddrA), .raddrB(raddrB),
        .rdataA(z_rdA), .rdataB(z_rdB), .rbusyA(z_rbA), .rbusyB(z_rbB),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .busy_cnt(z_cnt), .err_waw(z_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled 1 unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        issue_en = 1'b0; issue_addr = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        raddrA = '0;
        raddrB = '0;
        rst_n  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset: preload, then reset with a concurrent write and issue
        we0 = 1'b1; waddr0 = 3'd1; wdata0 = 8'h55;
        we1 = 1'b1; waddr1 = 3'd6; wdata1 = 8'h66;
        issue_en = 1'b1; issue_addr = 3'd2;
        tick();
        idle();
        raddrA = 3'd1; raddrB = 3'd6;
        #1;
        check("preload_rdA", 32'(b_rdA), 32'h55);
        check("preload_rdB", 32'(n_rdB), 32'h66);
        check("preload_cnt", 32'(b_cnt), 32'd1);
        rst_n = 1'b0;
        we0 = 1'b1; waddr0 = 3'd1; wdata0 = 8'h77;
        issue_en = 1'b1; issue_addr = 3'd3;
        tick();
        rst_n = 1'b1;
        idle();
        raddrA = 3'd1; raddrB = 3'd2;
        #1;
        check("rst_rdA", 32'(b_rdA), 32'h00);
        check("rst_rdA_nb", 32'(n_rdA), 32'h00);
        check("rst_rbB", 32'(b_rbB), 32'd0);
        check("rst_cnt", 32'(b_cnt), 32'd0);
        check("rst_err", 32'(b_err), 32'd0);

        // Dual-write collision: port 1 wins in bypass and in storage
        we0 = 1'b1; waddr0 = 3'd3; wdata0 = 8'h11;
        we1 = 1'b1; waddr1 = 3'd3; wdata1 = 8'h22;
        raddrA = 3'd3;
        #1;
        check("coll_byp_same", 32'(b_rdA), 32'h22);
        check("coll_nb_same", 32'(n_rdA), 32'h00);
        tick();
        idle();
        #1;
        check("coll_byp_after", 32'(b_rdA), 32'h22);
        check("coll_nb_after", 32'(n_rdA), 32'h22);

        // Bypass off: new data appears one cycle later
        we0 = 1'b1; waddr0 = 3'd5; wdata0 = 8'hA5;
        raddrA = 3'd5;
        #1;
        check("nb_old", 32'(n_rdA), 32'h00);
        check("byp_new", 32'(b_rdA), 32'hA5);
        tick();
        idle();
        #1;
        check("nb_new", 32'(n_rdA), 32'hA5);

        // Scoreboard: issue, then retire through port 1
        issue_en = 1'b1; issue_addr = 3'd2;
        raddrA = 3'd2;
        #1;
        check("sb_no_fwd", 32'(b_rbA), 32'd0);
        tick();
        idle();
        #1;
        check("sb_busy", 32'(b_rbA), 32'd1);
        check("sb_cnt1", 32'(b_cnt), 32'd1);
        check("sb_cnt1_nb", 32'(n_cnt), 32'd1);
        we1 = 1'b1; waddr1 = 3'd2; wdata1 = 8'h7E;
        #1;
        check("sb_clr_rb", 32'(b_rbA), 32'd0);
        check("sb_clr_rd", 32'(b_rdA), 32'h7E);
        check("sb_clr_nb_rb", 32'(n_rbA), 32'd1);
        tick();
        idle();
        #1;
        check("sb_cnt0", 32'(b_cnt), 32'd0);
        check("sb_nb_rb0", 32'(n_rbA), 32'd0);

        // Set/clear race: set wins, no WAW error
        we0 = 1'b1; waddr0 = 3'd4; wdata0 = 8'h44;
        issue_en = 1'b1; issue_addr = 3'd4;
        raddrB = 3'd4;
        tick();
        idle();
        #1;
        check("race_busy", 32'(b_rbB), 32'd1);
        check("race_err", 32'(b_err), 32'd0);
        check("race_cnt", 32'(b_cnt), 32'd1);
        // Re-issue on a busy entry while it is being written: still no error
        we1 = 1'b1; waddr1 = 3'd4; wdata1 = 8'h45;
        issue_en = 1'b1; issue_addr = 3'd4;
        tick();
        idle();
        #1;
        check("waw_masked_err", 32'(b_err), 32'd0);
        check("waw_masked_cnt", 32'(b_cnt), 32'd1);
        issue_en = 1'b1; issue_addr = 3'd4;
        tick();
        idle();
        #1;
        check("waw_err", 32'(b_err), 32'd1);
        tick();
        tick();
        check("waw_sticky", 32'(b_err), 32'd1);
        do_reset();
        #1;
        check("waw_rst", 32'(b_err), 32'd0);

        // Zero register: writes and issues to entry 0 are dropped
        we0 = 1'b1; waddr0 = 3'd0; wdata0 = 8'hFF;
        issue_en = 1'b1; issue_addr = 3'd0;
        raddrA = 3'd0;
        #1;
        check("z_rd_same", 32'(z_rdA), 32'h00);
        check("z_byp_ref", 32'(b_rdA), 32'hFF);
        tick();
        idle();
        #1;
        check("z_rd_after", 32'(z_rdA), 32'h00);
        check("z_rb_after", 32'(z_rbA), 32'd0);
        check("z_cnt0", 32'(z_cnt), 32'd0);
        check("z_ref_cnt", 32'(b_cnt), 32'd1);
        issue_en = 1'b1; issue_addr = 3'd0;
        tick();
        idle();
        #1;
        check("z_err0", 32'(z_err), 32'd0);
        check("z_ref_err", 32'(b_err), 32'd1);
        for (int a = 1; a < 8; a++) begin
            issue_en = 1'b1;
            issue_addr = AW'(a);
            tick();
        end
        idle();
        raddrB = 3'd7;
        #1;
        check("z_cnt_full", 32'(z_cnt), 32'd7);
        check("z_rbB7", 32'(z_rbB), 32'd1);
        check("ref_cnt_full", 32'(b_cnt), 32'd8);
        check("z_err_still0", 32'(z_err), 32'd0);
        issue_en = 1'b1; issue_addr = 3'd1;
        tick();
        idle();
        #1;
        check("z_waw_err", 32'(z_err), 32'd1);
        check("z_cnt_hold", 32'(z_cnt), 32'd7);
        // Two retirements in one cycle drop the count by two
        we0 = 1'b1; waddr0 = 3'd1; wdata0 = 8'h01;
        we1 = 1'b1; waddr1 = 3'd2; wdata1 = 8'h02;
        tick();
        idle();
        #1;
        check("z_cnt_dual", 32'(z_cnt), 32'd5);
        check("ref_cnt_dual", 32'(b_cnt), 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with two write ports, two combinational read ports, optional write-through bypass, optional hardwired-zero entry 0, and a per-entry busy scoreboard. It is the next generation of the 8x8 CPU register file. It adds a second write-back path and a scoreboard, so the decode stage can detect read-after-write hazards on multi-cycle results. Sits between decode (read and issue) and the two write-back paths (ALU on port 0, load/multi-cycle on port 1).

## Interface
- DATA_W, 8, data width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries
- BYPASS, 1, 1 = same-cycle write data and busy-clear are forwarded to read ports; 0 = no forwarding
- ZERO_REG, 0, 1 = entry 0 always reads 0, ignores writes, never goes busy

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- we0  in  1  write enable, port 0
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (wins over port 0 on same address)
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- raddrA / raddrB  in  ADDR_W  read addresses
- rdataA / rdataB  out  DATA_W  read data (combinational)
- rbusyA / rbusyB  out  1  addressed entry has a result pending
- issue_en  in  1  mark issue_addr busy
- issue_addr  in  ADDR_W  destination being issued
- busy_cnt  out  ADDR_W+1  number of busy entries (registered)
- err_waw  out  1  sticky: issue to an already-busy entry

## Operation
- Storage: DEPTH x DATA_W flops, plus DEPTH busy bits, busy_cnt and err_waw.
- Write: at posedge, if weN then mem[waddrN] <= wdataN. If both ports target the same address, port 1's data is stored.
- Busy clear: any write (either port) clears busy[waddr] at that edge.
- Busy set: issue_en sets busy[issue_addr]. If a set and a clear hit the same address in the same cycle, the set wins: the entry stays/becomes busy.
- busy_cnt: next value = popcount of the next busy vector. It is a registered counter, updated incrementally or by popcount. It must equal the number of set busy bits after every edge.
- err_waw: set at posedge when issue_en is high and busy[issue_addr] is already 1, unless a write clears that address in the same cycle. Cleared only by reset.
- Read, BYPASS=1:
  - rdataX = wdata1 if we1 && waddr1==raddrX; else wdata0 if we0 && waddr0==raddrX; else mem[raddrX].
  - rbusyX = busy[raddrX] && !(any we with waddr==raddrX).
- Read, BYPASS=0: rdataX = mem[raddrX] and rbusyX = busy[raddrX]; new values are visible the cycle after the edge.
- ZERO_REG=1, address 0:
  - rdata = 0 and rbusy = 0.
  - Writes are dropped, including in the bypass path.
  - issue_en is ignored: no busy set, no err_waw, no busy_cnt change.

## Timing
- Reset (rst_n low at posedge): all mem = 0, all busy = 0, busy_cnt = 0, err_waw = 0.
  - Reset overrides any concurrent write or issue in that cycle.
  - After reset, rdataA/B = 0 and rbusyA/B = 0, given no bypass hit.
- Write latency: 0 cycles to the read port with BYPASS=1, 1 cycle with BYPASS=0.
- Issue latency: rbusy for the issued address rises the cycle after the issue_en edge. There is no same-cycle forwarding of issue_en.
- busy_cnt range 0..DEPTH; it never wraps. With ZERO_REG=1 the maximum is DEPTH-1.
- Reset asserted while entries are busy clears every entry; pending results that arrive later simply write and clear nothing.
- No handshake back-pressure: writes and issues are accepted every cycle.

## Test plan
- Reset: preload entries, assert rst_n=0 for one edge -> all reads 0, rbusy 0, busy_cnt 0, err_waw 0.
- Dual-write collision (BYPASS=1): we0 addr3=0x11 and we1 addr3=0x22 in the same cycle, raddrA=3 -> rdataA=0x22 in that cycle and 0x22 after the edge.
- Bypass off: BYPASS=0, write addr5=0xA5 with raddrA=5 -> old value (0x00) in the cycle, 0xA5 in the next cycle.
- Scoreboard: issue addr2 -> next cycle rbusyA(2)=1, busy_cnt=1. Write port1 addr2=0x7E -> same cycle rbusyA=0 and rdataA=0x7E; after the edge busy_cnt=0.
- Set/clear race and WAW:
  - Write addr4 and issue addr4 in the same cycle -> busy[4]=1, err_waw=0.
  - Issue addr4 again with no write -> err_waw=1 and stays 1 until reset.
- ZERO_REG=1: write addr0=0xFF and issue addr0 -> rdata(0)=0, rbusy(0)=0, busy_cnt and err_waw unchanged. Then fill all 7 other entries busy -> busy_cnt=7.
